// File: rtl/dec_entry_pkg.sv
// Shared definitions for the decimal operand entry path.
// Holds the digit count, the saturation limit, the BCD digit width,
// the accumulator width used by the Horner conversion and the FSM states.
package dec_entry_pkg;

    localparam int NDIG   = 5;            // digits held in the echo register
    localparam int MAXVAL = 32767;        // largest magnitude before saturation
    localparam int DIG_W  = 4;            // one BCD digit
    localparam int BCD_W  = NDIG * DIG_W; // 20-bit echo value
    localparam int ACC_W  = 17;           // 99999 fits in 17 bits

    typedef enum logic [1:0] {
        ST_ENTRY = 2'd0,
        ST_CONV  = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/dec_entry_mul10_add.sv
// mul10_add: combinational acc*10 + digit using shifts and adds only.
// Ports:
//   acc    - 17-bit running value
//   digit  - 4-bit BCD digit to append
//   result - acc*10 + digit, 17 bits (callers keep acc <= 9999 so it fits)
module mul10_add
    import dec_entry_pkg::*;
(
    input  logic [ACC_W-1:0] acc,
    input  logic [DIG_W-1:0] digit,
    output logic [ACC_W-1:0] result
);

    logic [ACC_W-1:0] times8;
    logic [ACC_W-1:0] times2;
    logic [ACC_W-1:0] digit_ext;

    assign times8    = acc << 3;
    assign times2    = acc << 1;
    assign digit_ext = {{(ACC_W-DIG_W){1'b0}}, digit};
    assign result    = times8 + times2 + digit_ext;

endmodule

// File: rtl/dec_entry.sv
// dec_entry: decimal operand entry for the ALU16 front end.
// Collects up to five BCD digits from the keypad, echoes them for the
// seven-segment driver, and on enter converts them (one digit per cycle,
// most significant first) into a saturating 15-bit magnitude.
// Ports:
//   clk, rst_n    - clock (rising edge), asynchronous active-low reset
//   digit_in      - BCD digit from keypad, qualified by digit_valid
//   digit_ready   - a digit would be accepted this cycle
//   clear         - discard entry, abort a running conversion
//   enter         - start converting the held digits
//   bcd_out       - echo of held digits, [3:0] most recent
//   digit_cnt     - number of digits held (0..5)
//   digit_err     - one-cycle pulse after a rejected digit
//   busy          - conversion in progress
//   bin_out       - converted operand, bit 15 always 0
//   bin_valid     - one-cycle pulse when bin_out is updated
//   overflow      - last conversion saturated
module dec_entry
    import dec_entry_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIG_W-1:0]  digit_in,
    input  logic              digit_valid,
    output logic              digit_ready,
    input  logic              clear,
    input  logic              enter,
    output logic [BCD_W-1:0]  bcd_out,
    output logic [2:0]        digit_cnt,
    output logic              digit_err,
    output logic              busy,
    output logic [15:0]       bin_out,
    output logic              bin_valid,
    output logic              overflow
);

    localparam logic [2:0]       CNT_MAX  = 3'(NDIG);
    localparam logic [2:0]       STEP_TOP = 3'(NDIG - 1);
    localparam logic [ACC_W-1:0] ACC_MAX  = ACC_W'(MAXVAL);

    state_t           state;
    state_t           state_next;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_step;
    logic [2:0]       step;
    logic [BCD_W-1:0] bcd_next;
    logic [2:0]       cnt_next;
    logic             digit_ok;
    logic             digit_take;
    logic             digit_reject;

    // Pick digit idx out of the echo register; idx 4 is the oldest digit.
    function automatic logic [DIG_W-1:0] sel_digit(input logic [BCD_W-1:0] v,
                                                   input logic [2:0]       idx);
        logic [DIG_W-1:0] d;
        case (idx)
            3'd1:    d = v[7:4];
            3'd2:    d = v[11:8];
            3'd3:    d = v[15:12];
            3'd4:    d = v[19:16];
            default: d = v[3:0];
        endcase
        return d;
    endfunction

    mul10_add u_mul10_add (
        .acc    (acc),
        .digit  (sel_digit(bcd_out, step)),
        .result (acc_step)
    );

    // Clear outranks enter, enter outranks a digit on the same cycle.
    assign digit_ok     = (digit_in <= 4'd9) && (digit_cnt < CNT_MAX);
    assign digit_take   = (state == ST_ENTRY) && !clear && !enter && digit_valid && digit_ok;
    assign digit_reject = (state == ST_ENTRY) && !clear && !enter && digit_valid && !digit_ok;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_ENTRY;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_ENTRY: begin
                if (!clear && enter) begin
                    state_next = ST_CONV;
                end
            end
            ST_CONV: begin
                if (clear) begin
                    state_next = ST_ENTRY;
                end else if (step == 3'd0) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE:  state_next = ST_ENTRY;
            default:  state_next = ST_ENTRY;
        endcase
    end

    // Next echo value and digit count
    always_comb begin
        bcd_next = bcd_out;
        cnt_next = digit_cnt;
        case (state)
            ST_ENTRY: begin
                if (clear) begin
                    bcd_next = '0;
                    cnt_next = 3'd0;
                end else if (digit_take) begin
                    bcd_next = {bcd_out[BCD_W-DIG_W-1:0], digit_in};
                    cnt_next = digit_cnt + 3'd1;
                end
            end
            ST_CONV: begin
                if (clear) begin
                    bcd_next = '0;
                    cnt_next = 3'd0;
                end
            end
            default: begin
                bcd_next = '0;
                cnt_next = 3'd0;
            end
        endcase
    end

    // Registered outputs and conversion datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_out     <= '0;
            digit_cnt   <= 3'd0;
            digit_err   <= 1'b0;
            digit_ready <= 1'b1;
            busy        <= 1'b0;
            bin_out     <= 16'h0000;
            bin_valid   <= 1'b0;
            overflow    <= 1'b0;
            acc         <= '0;
            step        <= 3'd0;
        end else begin
            bcd_out     <= bcd_next;
            digit_cnt   <= cnt_next;
            digit_err   <= digit_reject;
            digit_ready <= (state_next == ST_ENTRY) && (cnt_next < CNT_MAX);
            busy        <= (state_next != ST_ENTRY);
            bin_valid   <= 1'b0;

            case (state)
                ST_ENTRY: begin
                    if (!clear && enter) begin
                        acc  <= '0;
                        step <= STEP_TOP;
                    end
                end
                ST_CONV: begin
                    if (!clear) begin
                        acc  <= acc_step;
                        step <= step - 3'd1;
                    end
                end
                ST_DONE: begin
                    bin_valid <= 1'b1;
                    if (acc > ACC_MAX) begin
                        bin_out  <= 16'h7FFF;
                        overflow <= 1'b1;
                    end else begin
                        bin_out  <= {1'b0, acc[14:0]};
                        overflow <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dec_entry.sv
module tb_dec_entry;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  digit_in = 4'd0;
    logic        digit_valid = 1'b0;
    logic        digit_ready;
    logic        clear = 1'b0;
    logic        enter = 1'b0;
    logic [19:0] bcd_out;
    logic [2:0]  digit_cnt;
    logic        digit_err;
    logic        busy;
    logic [15:0] bin_out;
    logic        bin_valid;
    logic        overflow;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    typedef struct {
        logic [15:0] bin;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    dec_entry dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .digit_in    (digit_in),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .clear       (clear),
        .enter       (enter),
        .bcd_out     (bcd_out),
        .digit_cnt   (digit_cnt),
        .digit_err   (digit_err),
        .busy        (busy),
        .bin_out     (bin_out),
        .bin_valid   (bin_valid),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    // Monitor: every bin_valid pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && bin_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_bin_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("bin_out", {16'h0, bin_out}, {16'h0, e.bin});
                check("overflow", {31'h0, overflow}, {31'h0, e.ovf});
                check("bin_latency", cyc, e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_digit(input logic [3:0] d);
        digit_in    = d;
        digit_valid = 1'b1;
        tick();
        digit_valid = 1'b0;
        digit_in    = 4'd0;
    endtask

    task automatic send_digits(input logic [3:0] ds[$]);
        foreach (ds[i]) send_digit(ds[i]);
    endtask

    // Enter is sampled at the next edge k; the result is expected after edge k+6.
    task automatic press_enter(input bit expect_res, input logic [15:0] b, input logic ovf);
        if (expect_res) begin
            exp_t e;
            e.bin = b;
            e.ovf = ovf;
            e.cyc = cyc + 7;
            sb.push_back(e);
        end
        enter = 1'b1;
        tick();
        enter = 1'b0;
    endtask

    task automatic convert(input string name, input logic [3:0] ds[$],
                           input logic [15:0] b, input logic ovf);
        send_digits(ds);
        press_enter(1'b1, b, ovf);
        check({name, "_busy"}, {31'h0, busy}, 32'd1);
        repeat (7) tick();
        check({name, "_cnt_after"}, {29'h0, digit_cnt}, 32'd0);
        check({name, "_busy_after"}, {31'h0, busy}, 32'd0);
        check({name, "_bin_held"}, {16'h0, bin_out}, {16'h0, b});
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_bcd", {12'h0, bcd_out}, 32'h0);
        check("rst_cnt", {29'h0, digit_cnt}, 32'd0);
        check("rst_bin", {16'h0, bin_out}, 32'h0);
        check("rst_ovf", {31'h0, overflow}, 32'd0);
        check("rst_flags", {29'h0, digit_err, bin_valid, busy}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("rst_ready", {31'h0, digit_ready}, 32'd1);

        // 12345: echo held through conversion
        send_digits('{4'd1, 4'd2, 4'd3, 4'd4, 4'd5});
        check("c1_cnt", {29'h0, digit_cnt}, 32'd5);
        check("c1_ready_full", {31'h0, digit_ready}, 32'd0);
        press_enter(1'b1, 16'h3039, 1'b0);
        check("c1_busy", {31'h0, busy}, 32'd1);
        tick();
        check("c1_bcd_conv", {12'h0, bcd_out}, 32'h12345);
        repeat (6) tick();
        check("c1_cnt_after", {29'h0, digit_cnt}, 32'd0);
        check("c1_bcd_after", {12'h0, bcd_out}, 32'h0);
        check("c1_busy_after", {31'h0, busy}, 32'd0);

        // Saturation boundaries
        convert("c32767", '{4'd3, 4'd2, 4'd7, 4'd6, 4'd7}, 16'h7FFF, 1'b0);
        convert("c32768", '{4'd3, 4'd2, 4'd7, 4'd6, 4'd8}, 16'h7FFF, 1'b1);
        convert("c99999", '{4'd9, 4'd9, 4'd9, 4'd9, 4'd9}, 16'h7FFF, 1'b1);
        convert("cempty", '{}, 16'h0000, 1'b0);

        // Leading zeros count as digits
        send_digits('{4'd0, 4'd0, 4'd4, 4'd2});
        check("c42_bcd", {12'h0, bcd_out}, 32'h00042);
        check("c42_cnt", {29'h0, digit_cnt}, 32'd4);
        press_enter(1'b1, 16'h002A, 1'b0);
        repeat (7) tick();
        check("c42_bin", {16'h0, bin_out}, 32'h2A);

        // Non-BCD digit rejected
        send_digit(4'hA);
        check("bad_err", {31'h0, digit_err}, 32'd1);
        check("bad_cnt", {29'h0, digit_cnt}, 32'd0);
        tick();
        check("bad_err_pulse", {31'h0, digit_err}, 32'd0);

        // Sixth digit dropped when full
        send_digits('{4'd1, 4'd2, 4'd3, 4'd4, 4'd5});
        check("full_ready", {31'h0, digit_ready}, 32'd0);
        send_digit(4'd6);
        check("full_err", {31'h0, digit_err}, 32'd1);
        check("full_bcd", {12'h0, bcd_out}, 32'h12345);
        check("full_cnt", {29'h0, digit_cnt}, 32'd5);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_cnt", {29'h0, digit_cnt}, 32'd0);
        check("clr_ready", {31'h0, digit_ready}, 32'd1);
        check("clr_keeps_bin", {16'h0, bin_out}, 32'h2A);

        // Abort mid-conversion keeps previous result
        convert("c12345b", '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5}, 16'h3039, 1'b0);
        send_digits('{4'd1, 4'd2, 4'd3});
        press_enter(1'b0, 16'h0, 1'b0);
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("abort_busy", {31'h0, busy}, 32'd0);
        check("abort_cnt", {29'h0, digit_cnt}, 32'd0);
        check("abort_bcd", {12'h0, bcd_out}, 32'h0);
        repeat (8) tick();
        check("abort_bin", {16'h0, bin_out}, 32'h3039);

        // clear and enter together: clear wins
        send_digits('{4'd5, 4'd6});
        clear = 1'b1;
        enter = 1'b1;
        tick();
        clear = 1'b0;
        enter = 1'b0;
        check("ce_busy", {31'h0, busy}, 32'd0);
        check("ce_cnt", {29'h0, digit_cnt}, 32'd0);
        check("ce_bcd", {12'h0, bcd_out}, 32'h0);
        repeat (8) tick();

        // Asynchronous reset during conversion
        send_digits('{4'd7, 4'd7});
        press_enter(1'b0, 16'h0, 1'b0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_bin", {16'h0, bin_out}, 32'h0);
        check("arst_busy", {31'h0, busy}, 32'd0);
        check("arst_bcd", {12'h0, bcd_out}, 32'h0);
        check("arst_cnt", {29'h0, digit_cnt}, 32'd0);
        check("arst_flags", {29'h0, overflow, bin_valid, digit_err}, 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (10) tick();

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dec_entry.md
Name: dec_entry

Overview:
- Decimal operand entry for the ALU16 front end; the input-side counterpart of the binary-to-decimal display path.
- Accepts BCD digits one at a time from the keypad scanner and holds up to 5 digits as a BCD echo value, which can drive the seven-segment driver directly.
- On enter, converts the digits iteratively (Horner, one digit per cycle) to a 16-bit operand: MSB forced 0, 15-bit magnitude, saturating.

Parameters:
NDIG, 5, maximum digits held (fixed at 5 for the 20-bit echo; other values unsupported)
MAXVAL, 32767, largest representable magnitude; larger results saturate

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
digit_in  input  4  BCD digit from keypad
digit_valid  input  1  digit_in valid this cycle
digit_ready  output  1  block can accept a digit this cycle
clear  input  1  discard entry / abort conversion
enter  input  1  start conversion of held digits
bcd_out  output  20  echo digits, [3:0] = most recent, right-justified
digit_cnt  output  3  digits held, 0..5
digit_err  output  1  one-cycle pulse: rejected digit (>9 or entry full)
busy  output  1  conversion in progress
bin_out  output  16  converted operand, bit 15 always 0, held until next conversion
bin_valid  output  1  one-cycle pulse: bin_out updated
overflow  output  1  last conversion exceeded MAXVAL; held with bin_out

Behaviour:
- Reset (async, rst_n low): state ENTRY. bcd_out=0, digit_cnt=0, bin_out=0, overflow=0. digit_err, bin_valid and busy are 0. An internal accumulator and step counter are cleared. A reset during conversion aborts it; no bin_valid is produced.
- States:
  - ENTRY: idle/collecting.
  - CONV: 5 steps.
  - DONE: 1 cycle.
- Priority in ENTRY, per cycle: clear > enter > digit.
- digit_ready = (state==ENTRY) && (digit_cnt<5).
- Digit accept (ENTRY, digit_valid, digit_in<=9, digit_cnt<5): bcd_out <= {bcd_out[15:0],digit_in}; digit_cnt+1. Leading zeros count as digits.
- digit_valid with digit_in>9, or with digit_cnt==5, in ENTRY: digit dropped, digit_err pulses the next cycle.
- digit_valid outside ENTRY: ignored silently.
- clear in ENTRY: bcd_out=0, digit_cnt=0. bin_out and overflow are unchanged.
- enter in ENTRY (no clear): acc=0, step=4, go to CONV. busy=1 from the next cycle through DONE. enter with digit_cnt==0 converts to 0.
- CONV, each cycle: acc <= acc*10 + bcd_out[4*step+3:4*step]. Use a 17-bit acc (99999 fits). *10 is implemented as (acc<<3)+(acc<<1); no multiplier. After step 0, go to DONE. CONV is exactly 5 cycles.
- DONE:
  - If acc>MAXVAL: bin_out=16'h7FFF, overflow=1. Otherwise bin_out={1'b0,acc[14:0]}, overflow=0.
  - bin_valid=1 for this single cycle; bcd_out and digit_cnt are cleared; next state ENTRY.
- Latency: enter sampled at edge k gives bin_valid high in the cycle after edge k+6. That is, bin_out and bin_valid are registered at edge k+6 (5 CONV edges plus the DONE edge).
- clear during CONV: abort to ENTRY, bcd_out/digit_cnt cleared, no bin_valid, bin_out/overflow keep their previous values.
- enter during CONV/DONE: ignored.
- bcd_out is stable during CONV; the display shows the entered digits until DONE.
- All outputs are registered.

Decomposition:
- Shared package/header: NDIG, MAXVAL, state encodings (ENTRY, CONV, DONE), BCD digit width 4.
- One natural sub-module: mul10_add (17-bit acc, 4-bit digit -> 17-bit acc*10+digit), purely combinational shift-add. It is reusable by other entry paths.

Test Plan:
- Digits 1,2,3,4,5 then enter: bcd_out=20'h12345 during CONV; 6 cycles later bin_valid pulse, bin_out=16'h3039, overflow=0, digit_cnt=0.
- Digits 3,2,7,6,7 -> bin_out=16'h7FFF, overflow=0. Digits 3,2,7,6,8 -> bin_out=16'h7FFF, overflow=1. Digits 9,9,9,9,9 -> 16'h7FFF, overflow=1.
- Enter with no digits -> bin_out=0, overflow=0. Digits 0,0,4,2 -> bcd_out=20'h00042, result 16'h002A.
- Digit 4'hA -> digit_err pulse, digit_cnt unchanged. Six digits 1..6 -> sixth dropped, digit_err pulse, digit_ready=0 at cnt=5, bcd_out=20'h12345.
- Digits 1,2,3, enter, clear on 2nd CONV cycle -> ENTRY, no bin_valid, bin_out retains prior 16'h3039.
- clear and enter asserted together with 2 digits held -> entry cleared, no conversion. rst_n low mid-CONV -> all outputs 0 immediately, no bin_valid.
